// File: rtl/life_collision_mux_pkg.sv
// Shared types and constants for the life/collision pixel mux.
package life_collision_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    COOLDOWN  = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam int LIVES_W = 4;

  // Layers drop their DR on transparent pixels, so the mux keys on DR alone.
  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

endpackage

// File: rtl/life_collision_mux_frame_event_latch.sv
// Per-frame sticky overlap flag with a registered one-cycle event pulse
// emitted at startOfFrame when the caller enables it.
module frame_event_latch (
  input  logic clk,
  input  logic resetN,
  input  logic start_of_frame,
  input  logic set_i,
  input  logic clear_i,
  input  logic apply_i,
  output logic flag_o,
  output logic pulse_o
);

  logic flag_q, flag_d;
  logic pulse_q, pulse_d;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    flag_d  = flag_q | set_i;
    pulse_d = 1'b0;
    if (clear_i) begin
      flag_d = 1'b0;
    end else if (start_of_frame) begin
      // An overlap in the start-of-frame cycle already belongs to the new frame.
      flag_d  = set_i;
      pulse_d = flag_q & apply_i;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
    end
  end

  assign flag_o  = flag_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/life_collision_mux.sv
// Layer-priority pixel mux with per-frame collision tracking and a lives FSM.
// Optional player blink during cooldown: define LIFE_COLLISION_BLINK_EN.
module life_collision_mux
  import life_collision_pkg::*;
#(
  parameter int MAX_LIVES       = 5,
  parameter int INIT_LIVES      = 3,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               playerDR,
  input  logic [7:0]         playerRGB,
  input  logic               enemyDR,
  input  logic [7:0]         enemyRGB,
  input  logic               lifeDR,
  input  logic [7:0]         lifeRGB,
  input  logic [7:0]         backGroundRGB,
  input  logic               gameRestart,
  output logic [7:0]         RGBout,
  output logic               enemyCollision,
  output logic               lifeCollision,
  output logic [LIVES_W-1:0] livesCount,
  output logic               gameOver
);

  localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

  state_t                     state_q, state_d;
  logic   [CNT_W-1:0]         cnt_q, cnt_d;
  logic   [LIVES_W-1:0]       lives_q, lives_d, lives_clamped;
  logic   [7:0]               rgb_q, rgb_d;
  logic signed [LIVES_W:0]    lives_sum;
  logic                       enemy_flag, life_flag, hit, pick, player_vis;

  // Restart outranks frame evaluation, so it also suppresses the pulses.
  assign hit  = startOfFrame & ~gameRestart & enemy_flag & (state_q == PLAY);
  assign pick = startOfFrame & ~gameRestart & life_flag  & (state_q != GAME_OVER);

  frame_event_latch u_enemy_latch (
    .clk           (clk),
    .resetN        (resetN),
    .start_of_frame(startOfFrame),
    .set_i         (playerDR & enemyDR),
    .clear_i       (gameRestart),
    .apply_i       (state_q == PLAY),
    .flag_o        (enemy_flag),
    .pulse_o       (enemyCollision)
  );

  frame_event_latch u_life_latch (
    .clk           (clk),
    .resetN        (resetN),
    .start_of_frame(startOfFrame),
    .set_i         (playerDR & lifeDR),
    .clear_i       (gameRestart),
    .apply_i       (state_q != GAME_OVER),
    .flag_o        (life_flag),
    .pulse_o       (lifeCollision)
  );

  always_comb begin
    lives_sum = $signed({1'b0, lives_q}) - $signed({{LIVES_W{1'b0}}, hit})
              + $signed({{LIVES_W{1'b0}}, pick});
    if (int'(lives_sum) < 0) begin
      lives_clamped = '0;
    end else if (int'(lives_sum) > MAX_LIVES) begin
      lives_clamped = LIVES_W'(MAX_LIVES);
    end else begin
      lives_clamped = lives_sum[LIVES_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    if (gameRestart) begin
      state_d = PLAY;
      cnt_d   = '0;
      lives_d = LIVES_W'(INIT_LIVES);
    end else if (startOfFrame) begin
      case (state_q)
        PLAY: begin
          lives_d = lives_clamped;
          if (hit && lives_clamped == '0) begin
            state_d = GAME_OVER;
          end else if (hit) begin
            state_d = COOLDOWN;
            cnt_d   = CNT_W'(COOLDOWN_FRAMES - 1);
          end
        end
        COOLDOWN: begin
          lives_d = lives_clamped;
          if (cnt_q == '0) state_d = PLAY;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef LIFE_COLLISION_BLINK_EN
  logic [3:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (startOfFrame) begin
      frame_cnt_d = (state_q != COOLDOWN && state_d == COOLDOWN) ? 4'd0 : frame_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) frame_cnt_q <= 4'd0;
    else         frame_cnt_q <= frame_cnt_d;
  end

  // Blink only hides the colour; overlap latches still see the raw playerDR.
  assign player_vis = playerDR & ~((state_q == COOLDOWN) & frame_cnt_q[3]);
`else
  assign player_vis = playerDR;
`endif

  always_comb begin
    if (player_vis)   rgb_d = playerRGB;
    else if (enemyDR) rgb_d = enemyRGB;
    else if (lifeDR)  rgb_d = lifeRGB;
    else              rgb_d = backGroundRGB;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= PLAY;
      cnt_q   <= '0;
      lives_q <= LIVES_W'(INIT_LIVES);
      rgb_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lives_q <= lives_d;
      rgb_q   <= rgb_d;
    end
  end

  assign RGBout     = rgb_q;
  assign livesCount = lives_q;
  assign gameOver   = (state_q == GAME_OVER);

endmodule

// File: tb/tb_life_collision_mux.sv
// Randomized and directed bench for life_collision_mux against a frame-level model.
module tb_life_collision_mux;

  localparam int MAX_L  = 5;
  localparam int INIT_L = 3;
  localparam int CD     = 60;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, playerDR, enemyDR, lifeDR, gameRestart;
  logic [7:0] playerRGB, enemyRGB, lifeRGB, backGroundRGB;
  logic [7:0] RGBout;
  logic       enemyCollision, lifeCollision, gameOver;
  logic [3:0] livesCount;

  life_collision_mux #(
    .MAX_LIVES(MAX_L), .INIT_LIVES(INIT_L), .COOLDOWN_FRAMES(CD)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .playerDR(playerDR), .playerRGB(playerRGB),
    .enemyDR(enemyDR), .enemyRGB(enemyRGB),
    .lifeDR(lifeDR), .lifeRGB(lifeRGB),
    .backGroundRGB(backGroundRGB), .gameRestart(gameRestart),
    .RGBout(RGBout), .enemyCollision(enemyCollision), .lifeCollision(lifeCollision),
    .livesCount(livesCount), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: lives as an integer, cooldown as a window of frame numbers.
  int         m_lives, m_frame, m_hit_frame;
  bit         m_over, m_has_hit, m_enemy_seen, m_life_seen;
  logic [7:0] exp_rgb;
  bit         exp_ecol, exp_lcol;

  function automatic bit m_cooling();
    return !m_over && m_has_hit && (m_frame - m_hit_frame) < CD;
  endfunction

  task automatic model_reset();
    m_lives = INIT_L; m_frame = 0; m_hit_frame = 0;
    m_over = 0; m_has_hit = 0; m_enemy_seen = 0; m_life_seen = 0;
    exp_rgb = 8'h00; exp_ecol = 0; exp_lcol = 0;
  endtask

  task automatic model_step();
    bit show_p, hit, pick;
    show_p = playerDR;
`ifdef LIFE_COLLISION_BLINK_EN
    if (m_cooling() && (((m_frame - m_hit_frame) & 8) != 0)) show_p = 0;
`endif
    exp_rgb  = show_p ? playerRGB : enemyDR ? enemyRGB : lifeDR ? lifeRGB : backGroundRGB;
    exp_ecol = 0;
    exp_lcol = 0;
    if (gameRestart) begin
      m_lives = INIT_L; m_over = 0; m_has_hit = 0;
      m_enemy_seen = 0; m_life_seen = 0;
    end else if (startOfFrame) begin
      hit  = m_enemy_seen && !m_over && !m_cooling();
      pick = m_life_seen && !m_over;
      if (!m_over) begin
        m_lives = m_lives - int'(hit) + int'(pick);
        if (m_lives < 0)     m_lives = 0;
        if (m_lives > MAX_L) m_lives = MAX_L;
        if (hit) begin
          if (m_lives == 0) m_over = 1;
          else begin m_has_hit = 1; m_hit_frame = m_frame + 1; end
        end
      end
      exp_ecol = hit;
      exp_lcol = pick;
      m_enemy_seen = playerDR && enemyDR;
      m_life_seen  = playerDR && lifeDR;
    end else begin
      m_enemy_seen = m_enemy_seen || (playerDR && enemyDR);
      m_life_seen  = m_life_seen  || (playerDR && lifeDR);
    end
    if (startOfFrame) m_frame++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rgb",         32'(RGBout),         32'(exp_rgb));
      check("enemy_pulse", 32'(enemyCollision), 32'(exp_ecol));
      check("life_pulse",  32'(lifeCollision),  32'(exp_lcol));
      check("lives",       32'(livesCount),     32'(m_lives));
      check("game_over",   32'(gameOver),       32'(m_over));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit sof, input bit p, input bit e, input bit l, input bit r);
    startOfFrame = sof; playerDR = p; enemyDR = e; lifeDR = l; gameRestart = r;
    playerRGB = 8'($urandom); enemyRGB = 8'($urandom);
    lifeRGB = 8'($urandom); backGroundRGB = 8'($urandom);
    tick();
  endtask

  task automatic sof_cycle();
    drive(1, 0, 0, 0, 0);
  endtask

  // en cycles of player/enemy overlap, then li of player/life, then overlap-free noise.
  task automatic body(input int len, input int en, input int li);
    bit p;
    for (int i = 0; i < len; i++) begin
      if (i < en)           drive(0, 1, 1, 0, 0);
      else if (i < en + li) drive(0, 1, 0, 1, 0);
      else begin
        p = 1'($urandom);
        drive(0, p, !p && 1'($urandom), !p && 1'($urandom), 0);
      end
    end
  endtask

  task automatic frame(input int len, input int en, input int li);
    sof_cycle();
    body(len - 1, en, li);
  endtask

  task automatic hit_and_wait();
    body(5, 2, 0);
    sof_cycle();
    for (int i = 0; i < CD; i++) begin
      body(2, 0, 0);
      sof_cycle();
    end
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 0; playerDR = 0; enemyDR = 0; lifeDR = 0; gameRestart = 0;
    playerRGB = 0; enemyRGB = 0; lifeRGB = 0; backGroundRGB = 0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_lives", 32'(livesCount), 32'd3);
    check("reset_rgb",   32'(RGBout),     32'h00);
    check("reset_over",  32'(gameOver),   32'd0);
    #2 resetN = 1'b1;

    // Priority: player over enemy, then background fill.
    playerDR = 1; playerRGB = 8'h1C; enemyDR = 1; enemyRGB = 8'hE0;
    lifeDR = 0; lifeRGB = 8'h55; backGroundRGB = 8'h03;
    tick();
    check("prio_player", 32'(RGBout), 32'h1C);
    playerDR = 0; enemyDR = 0;
    tick();
    check("prio_background", 32'(RGBout), 32'h03);
    drive(0, 0, 0, 0, 1);

    // Single enemy hit, then 60 ignored frames, then a counted one.
    frame(8, 3, 0);
    sof_cycle();
    check("hit_pulse", 32'(enemyCollision), 32'd1);
    check("hit_lives", 32'(livesCount),     32'd2);
    drive(0, 0, 0, 0, 0);
    check("hit_pulse_width", 32'(enemyCollision), 32'd0);
    body(6, 2, 0);
    for (int k = 1; k < CD; k++) frame(8, 2, 0);
    sof_cycle();
    check("cooldown_lives", 32'(livesCount),     32'd2);
    check("cooldown_pulse", 32'(enemyCollision), 32'd0);
    body(7, 2, 0);
    sof_cycle();
    check("post_cooldown_lives", 32'(livesCount),     32'd1);
    check("post_cooldown_pulse", 32'(enemyCollision), 32'd1);

    // Pickups during cooldown up to saturation.
    body(5, 0, 1);
    for (int i = 0; i < 4; i++) begin
      sof_cycle();
      body(5, 0, 1);
    end
    sof_cycle();
    check("sat_pulse", 32'(lifeCollision), 32'd1);
    check("sat_lives", 32'(livesCount),    32'd5);

    // Simultaneous hit and pickup at one life, then game over and restart.
    drive(0, 0, 0, 0, 1);
    check("restart_lives", 32'(livesCount), 32'd3);
    hit_and_wait();
    hit_and_wait();
    body(6, 2, 2);
    sof_cycle();
    check("simul_enemy", 32'(enemyCollision), 32'd1);
    check("simul_life",  32'(lifeCollision),  32'd1);
    check("simul_lives", 32'(livesCount),     32'd1);
    check("simul_over",  32'(gameOver),       32'd0);
    for (int i = 0; i < CD; i++) begin
      body(2, 0, 0);
      sof_cycle();
    end
    body(5, 2, 0);
    sof_cycle();
    check("over_lives", 32'(livesCount), 32'd0);
    check("over_flag",  32'(gameOver),   32'd1);
    body(5, 2, 2);
    sof_cycle();
    check("over_no_enemy", 32'(enemyCollision), 32'd0);
    check("over_no_life",  32'(lifeCollision),  32'd0);
    drive(0, 0, 0, 0, 1);
    check("over_restart_flag",  32'(gameOver),   32'd0);
    check("over_restart_lives", 32'(livesCount), 32'd3);

    // Restart coinciding with startOfFrame suppresses the pending hit.
    body(5, 2, 0);
    drive(1, 0, 0, 0, 1);
    check("restart_sof_pulse", 32'(enemyCollision), 32'd0);
    check("restart_sof_lives", 32'(livesCount),     32'd3);

    // Random frames with overlaps allowed anywhere, including on startOfFrame.
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(3, 12);
      drive(1, 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      for (int i = 0; i < len; i++)
        drive(0, 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset mid-cycle from a non-reset state.
    drive(0, 0, 0, 0, 1);
    body(4, 2, 0);
    sof_cycle();
    playerDR = 1; playerRGB = 8'hA5; enemyDR = 0; lifeDR = 0; startOfFrame = 0;
    tick();
    #2 resetN = 1'b0;
    model_reset();
    #1;
    check("async_rgb",   32'(RGBout),         32'h00);
    check("async_lives", 32'(livesCount),     32'd3);
    check("async_over",  32'(gameOver),       32'd0);
    check("async_pulse", 32'(enemyCollision), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2 resetN = 1'b1;
    frame(6, 2, 0);
    sof_cycle();
    check("after_reset_lives", 32'(livesCount), 32'd2);
    body(4, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
